// File: rtl/hex_display_arbiter_if.sv
// Request/data/lock bundle between the debug taps and the display arbiter.
// The master side offers values; the slave side (arbiter) returns grant, ack and display data.
interface hex_display_arbiter_if;
  logic [3:0]  req;
  logic [15:0] src0_data;
  logic [15:0] src1_data;
  logic [15:0] src2_data;
  logic [15:0] src3_data;
  logic        lock;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic [15:0] data_out;
  logic        busy;

  modport master (
    output req, src0_data, src1_data, src2_data, src3_data, lock,
    input  grant, ack, data_out, busy
  );

  modport slave (
    input  req, src0_data, src1_data, src2_data, src3_data, lock,
    output grant, ack, data_out, busy
  );
endinterface

// File: rtl/hex_display_arbiter.sv
// Round-robin share of one 16-bit hex display among four sources; 1-cycle req-to-ack from IDLE,
// each grant dwells HOLD_CYCLES (lock stretches it); requests arriving mid-dwell wait for its end.
module hex_display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  hex_display_arbiter_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_SHOW} state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [1:0]        r_ptr, w_ptr_nxt;
  logic [3:0]        r_grant, w_grant_nxt;
  logic [3:0]        r_ack, w_ack_nxt;
  logic [15:0]       r_data, w_data_nxt;
  logic              r_busy, w_busy_nxt;

  logic [1:0]        w_win;
  logic [1:0]        w_idx;
  logic              w_any;
  logic [15:0]       w_win_data;

  // Scan from farthest to nearest so the nearest set bit after r_ptr wins.
  always_comb begin
    w_win = r_ptr;
    w_idx = r_ptr;
    w_any = |bus.req;
    for (int k = 4; k >= 1; k--) begin
      w_idx = r_ptr + 2'(k);
      if (bus.req[w_idx]) w_win = w_idx;
    end
  end

  always_comb begin
    case (w_win)
      2'd0:    w_win_data = bus.src0_data;
      2'd1:    w_win_data = bus.src1_data;
      2'd2:    w_win_data = bus.src2_data;
      default: w_win_data = bus.src3_data;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    w_ack_nxt   = 4'b0000;
    w_data_nxt  = r_data;
    w_busy_nxt  = r_busy;

    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = '0;
          w_ptr_nxt   = w_win;
          w_grant_nxt = 4'b0001 << w_win;
          w_ack_nxt   = 4'b0001 << w_win;
          w_data_nxt  = w_win_data;
          w_busy_nxt  = 1'b1;
        end
      end
      default: begin
        if (!bus.lock) begin
          if (r_cnt == LP_LAST) begin
            if (w_any) begin
              w_cnt_nxt   = '0;
              w_ptr_nxt   = w_win;
              w_grant_nxt = 4'b0001 << w_win;
              w_ack_nxt   = 4'b0001 << w_win;
              w_data_nxt  = w_win_data;
            end else begin
              w_state_nxt = ST_IDLE;
              w_grant_nxt = 4'b0000;
              w_busy_nxt  = 1'b0;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ptr   <= 2'd3;
      r_grant <= 4'b0000;
      r_ack   <= 4'b0000;
      r_data  <= 16'h0000;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_ack   <= w_ack_nxt;
      r_data  <= w_data_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign bus.grant    = r_grant;
  assign bus.ack      = r_ack;
  assign bus.data_out = r_data;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Bench for hex_display_arbiter with HOLD_CYCLES=4: directed scenarios plus random traffic,
// all compared against a dwell-countdown reference model of the display ownership.
module tb_hex_display_arbiter;

  localparam int HOLD = 4;

  logic clk;
  logic reset;
  hex_display_arbiter_if bus ();

  hex_display_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Reference model: who owns the display, for how many more unlocked cycles, and what it shows.
  int          m_owner;
  int          m_last;
  int          m_left;
  logic [15:0] m_data;
  logic        m_ack;
  logic        m_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] src_val(input int s);
    case (s)
      0:       return bus.src0_data;
      1:       return bus.src1_data;
      2:       return bus.src2_data;
      default: return bus.src3_data;
    endcase
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_left  = 0;
    m_data  = 16'h0000;
    m_ack   = 1'b0;
    m_busy  = 1'b0;
  endtask

  task automatic model_grant();
    int w;
    w = -1;
    for (int j = 4; j >= 1; j--)
      if (bus.req[(m_last + j) % 4]) w = (m_last + j) % 4;
    m_owner = w;
    m_last  = w;
    m_data  = src_val(w);
    m_ack   = 1'b1;
    m_left  = HOLD;
    m_busy  = 1'b1;
  endtask

  task automatic model_edge();
    m_ack = 1'b0;
    if (!m_busy) begin
      if (bus.req != 4'b0) model_grant();
    end else begin
      if (!bus.lock) m_left--;
      if (m_left == 0) begin
        if (bus.req != 4'b0) model_grant();
        else begin
          m_busy  = 1'b0;
          m_owner = -1;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [3:0] eg;
    eg = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    check_eq({tag, "_grant"}, 32'(bus.grant), 32'(eg));
    check_eq({tag, "_ack"},   32'(bus.ack),   32'(m_ack ? eg : 4'b0000));
    check_eq({tag, "_data"},  32'(bus.data_out), 32'(m_data));
    check_eq({tag, "_busy"},  32'(bus.busy),  32'(m_busy));
  endtask

  task automatic step(input string tag, input logic [3:0] rq, input logic lk,
                      input logic [15:0] d0, input logic [15:0] d1,
                      input logic [15:0] d2, input logic [15:0] d3);
    @(negedge clk);
    bus.req = rq; bus.lock = lk;
    bus.src0_data = d0; bus.src1_data = d1; bus.src2_data = d2; bus.src3_data = d3;
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b0;
    bus.req = 4'b0; bus.lock = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  int n_busy;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b0;
    bus.req = 4'b0; bus.lock = 1'b0;
    bus.src0_data = 16'h0; bus.src1_data = 16'h0; bus.src2_data = 16'h0; bus.src3_data = 16'h0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all("reset");
    reset = 1'b1;

    for (int i = 0; i < 10; i++) step("idle", 4'b0000, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Single request.
    n_busy = 0;
    step("single", 4'b0001, 1'b0, 16'h1234, 16'h0, 16'h0, 16'h0);
    check_eq("single_first_data", 32'(bus.data_out), 32'h1234);
    check_eq("single_first_ack", 32'(bus.ack), 32'h1);
    if (bus.busy) n_busy++;
    for (int i = 0; i < 6; i++) begin
      step("single", 4'b0000, 1'b0, 16'h9999, 16'h0, 16'h0, 16'h0);
      if (bus.busy) n_busy++;
    end
    check_eq("single_len", 32'(n_busy), 32'(HOLD));
    check_eq("single_keep", 32'(bus.data_out), 32'h1234);

    // Round robin from a fresh pointer.
    async_reset("rst_rr");
    for (int i = 0; i < 17; i++) begin
      step("rr", 4'b1111, 1'b0, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
      if (i % 4 == 0) begin
        check_eq("rr_ack_pulse", 32'(bus.ack), 32'(4'b0001 << ((i / 4) % 4)));
      end
    end
    for (int i = 0; i < 6; i++) step("drain", 4'b0000, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Lock stretches the dwell of src2 by 10 cycles.
    n_busy = 0;
    step("lock", 4'b0100, 1'b0, 16'h0, 16'h0, 16'h5A5A, 16'h0);
    if (bus.busy) n_busy++;
    for (int i = 0; i < 2; i++) begin
      step("lock", 4'b0000, 1'b0, 16'h0, 16'h0, 16'h1111, 16'h0);
      if (bus.busy) n_busy++;
    end
    for (int i = 0; i < 10; i++) begin
      step("lock", 4'b0000, 1'b1, 16'h0, 16'h0, 16'(i * 16'h0101), 16'h0);
      if (bus.busy) n_busy++;
    end
    for (int i = 0; i < 4; i++) begin
      step("lock", 4'b0000, 1'b0, 16'h0, 16'h0, 16'h2222, 16'h0);
      if (bus.busy) n_busy++;
    end
    check_eq("lock_len", 32'(n_busy), 32'd14);
    check_eq("lock_snap", 32'(bus.data_out), 32'h5A5A);

    // Snapshot and priority: pointer at 1, so src3 beats src0.
    step("prio", 4'b0010, 1'b0, 16'h0, 16'h4321, 16'h0, 16'h7777);
    for (int i = 0; i < HOLD; i++)
      step("prio", 4'b1001, 1'b0, 16'h0, 16'hFFFF, 16'h0, 16'h7777);
    check_eq("prio_next_grant", 32'(bus.grant), 32'b1000);
    check_eq("prio_next_data", 32'(bus.data_out), 32'h7777);
    for (int i = 0; i < 6; i++) step("drain", 4'b0000, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Reset in SHOW cycle 2, then src0 wins first again.
    step("midrst", 4'b0100, 1'b0, 16'h0, 16'h0, 16'h3333, 16'h0);
    step("midrst", 4'b0000, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    step("midrst", 4'b0000, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    async_reset("midrst_async");
    step("after_rst", 4'b1111, 1'b0, 16'h0ABC, 16'h1, 16'h2, 16'h3);
    check_eq("after_rst_grant", 32'(bus.grant), 32'b0001);

    // Random traffic with bursts of held requests and occasional lock.
    for (int i = 0; i < 800; i++) begin
      logic [3:0] rq;
      rq = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      step("rand", rq, ($urandom_range(0, 7) == 0), 16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom));
      if (i % 211 == 210) begin
        async_reset("rand_rst");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
